mixcolumns_seq: RTL and testbench

//  Iterative AES MixColumns stage that sits directly downstream of shiftrow and consumes its 128-bit output.

---
 rtl/mixcolumns_seq.sv | 120 ++++++++++++
 tb/tb_mixcolumns_seq.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/mixcolumns_seq.sv
// Iterative AES MixColumns stage: mixes COLS_PER_CYCLE columns per clock between valid/ready
// handshakes; last_round bypasses the mix.
module mixcolumns_seq #(
  parameter int unsigned COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  input  logic         last_round,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy
);

  if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cpc
    $error("mixcolumns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  // Column index of the last group; the step wraps col_idx back to 0 after column 3.
  localparam logic [1:0] LastIdx = 2'(4 - COLS_PER_CYCLE);
  localparam logic [1:0] ColStep = 2'(COLS_PER_CYCLE);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e       state_q, state_d;
  logic [1:0]   col_idx_q, col_idx_d;
  logic [127:0] src_q, src_d;
  logic         byp_q, byp_d;
  logic [127:0] out_state_q, out_state_d;
  logic         out_valid_q, out_valid_d;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] mul3(input logic [7:0] b);
    return xtime(b) ^ b;
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = col;
    return {xtime(a0) ^ mul3(a1) ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ mul3(a2) ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ mul3(a3),
            mul3(a0) ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  always_comb begin
    state_d     = state_q;
    col_idx_d   = col_idx_q;
    src_d       = src_q;
    byp_d       = byp_q;
    out_state_d = out_state_q;
    out_valid_d = out_valid_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          src_d     = in_state;
          byp_d     = last_round;
          col_idx_d = 2'd0;
          if (last_round) begin
            out_state_d = in_state;
            state_d     = StDone;
          end else begin
            state_d = StCalc;
          end
        end
      end
      StCalc: begin
        for (int unsigned k = 0; k < COLS_PER_CYCLE; k++) begin
          out_state_d[127 - 32 * ((32'(col_idx_q) + k) % 4) -: 32] =
              mix_col(src_q[127 - 32 * ((32'(col_idx_q) + k) % 4) -: 32]);
        end
        col_idx_d = col_idx_q + ColStep;
        if (col_idx_q == LastIdx) begin
          out_valid_d = 1'b1;
          state_d     = StDone;
        end
      end
      StDone: begin
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          state_d     = StIdle;
        end else if (byp_q) begin
          // Bypass enters DONE straight from IDLE; out_valid rises one cycle later.
          out_valid_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      col_idx_q   <= 2'd0;
      src_q       <= '0;
      byp_q       <= 1'b0;
      out_state_q <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_idx_q   <= col_idx_d;
      src_q       <= src_d;
      byp_q       <= byp_d;
      out_state_q <= out_state_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign busy      = (state_q != StIdle);
  assign out_valid = out_valid_q;
  assign out_state = out_state_q;

endmodule

// File: tb/tb_mixcolumns_seq.sv
// Self-checking bench for mixcolumns_seq: three instances (1, 2, 4 columns/cycle) checked
// against a GF(2^8) matrix-multiply reference model.
module tb_mixcolumns_seq;

  localparam logic [127:0] T1In  = 128'hdb135345_f20a225c_01010101_2d26314c;
  localparam logic [127:0] T1Out = 128'h8e4da1bc_9fdc589d_01010101_4d7ebdf8;
  localparam logic [127:0] T2In  = 128'h00112233_44556677_8899aabb_ccddeeff;
  localparam logic [127:0] C6In  = {4{32'hc6c6c6c6}};
  localparam logic [127:0] T6In  = {32'h0, 32'h0, 32'hd4d4d4d5, 32'h0};
  localparam logic [127:0] T6Out = {32'h0, 32'h0, 32'hd5d5d7d6, 32'h0};

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid   [3];
  logic         in_ready   [3];
  logic [127:0] in_state   [3];
  logic         last_round [3];
  logic         out_valid  [3];
  logic         out_ready  [3];
  logic [127:0] out_state  [3];
  logic         busy       [3];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mixcolumns_seq #(
      .COLS_PER_CYCLE((g == 0) ? 1 : ((g == 1) ? 2 : 4))
    ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .in_state  (in_state[g]),
      .last_round(last_round[g]),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .out_state (out_state[g]),
      .busy      (busy[g])
    );
  end

  function automatic int cpc(input int i);
    return (i == 0) ? 1 : ((i == 1) ? 2 : 4);
  endfunction

  // Generic shift-and-add multiply in GF(2^8) modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
    end
    return p;
  endfunction

  // Each output byte is a row of the circulant matrix (2 3 1 1) times the column.
  function automatic logic [127:0] mix_ref(input logic [127:0] s);
    logic [127:0] res;
    logic [7:0]   coef [4];
    logic [7:0]   acc;
    coef[0] = 8'd2; coef[1] = 8'd3; coef[2] = 8'd1; coef[3] = 8'd1;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        acc = 8'h00;
        for (int j = 0; j < 4; j++) acc ^= gf_mul(s[127 - 32*c - 8*j -: 8], coef[(j - r + 4) % 4]);
        res[127 - 32*c - 8*r -: 8] = acc;
      end
    end
    return res;
  endfunction

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // One transaction: accept, wait for out_valid, hold off out_ready for `hold` cycles, handshake.
  task automatic do_op(input int i, input logic [127:0] st, input logic lr,
                       input logic [127:0] exp, input int hold);
    int lat;
    @(negedge clk);
    check("in_ready_idle", in_ready[i], 1'b1);
    in_valid[i]   = 1'b1;
    in_state[i]   = st;
    last_round[i] = lr;
    @(posedge clk); #1;
    in_valid[i]   = 1'b0;
    in_state[i]   = rnd128();
    last_round[i] = 1'($urandom);
    check("busy_after_accept", busy[i], 1'b1);
    check("in_ready_after_accept", in_ready[i], 1'b0);
    lat = 0;
    while (!out_valid[i] && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency", 128'(lat), lr ? 128'd1 : 128'(4 / cpc(i)));
    check("out_state", out_state[i], exp);
    for (int k = 0; k < hold; k++) begin
      in_valid[i] = 1'($urandom);
      in_state[i] = rnd128();
      @(posedge clk); #1;
      check("hold_valid", out_valid[i], 1'b1);
      check("hold_state", out_state[i], exp);
      check("hold_in_ready", in_ready[i], 1'b0);
    end
    in_valid[i]  = 1'b0;
    out_ready[i] = 1'b1;
    @(posedge clk); #1;
    out_ready[i] = 1'b0;
    check("post_hs_valid", out_valid[i], 1'b0);
    check("post_hs_ready", in_ready[i], 1'b1);
    check("post_hs_busy", busy[i], 1'b0);
  endtask

  task automatic check_reset(input int i);
    check("rst_in_ready", in_ready[i], 1'b1);
    check("rst_out_valid", out_valid[i], 1'b0);
    check("rst_out_state", out_state[i], '0);
    check("rst_busy", busy[i], 1'b0);
  endtask

  task automatic back_to_back();
    int acc_cyc [4];
    int nacc = 0;
    int nout = 0;
    logic acc_now;
    @(negedge clk);
    in_valid[2]   = 1'b1;
    in_state[2]   = T1In;
    last_round[2] = 1'b0;
    out_ready[2]  = 1'b1;
    for (int c = 0; c < 20 && nout < 2; c++) begin
      if (c > 0) @(negedge clk);
      if (out_valid[2]) begin
        check(nout == 0 ? "b2b_out_t1" : "b2b_out_t2", out_state[2], nout == 0 ? T1Out : T2In);
        nout++;
      end
      acc_now = in_ready[2] && in_valid[2];
      @(posedge clk); #1;
      if (acc_now && nacc < 4) begin
        acc_cyc[nacc] = c;
        nacc++;
        if (nacc == 1) begin
          in_state[2]   = T2In;
          last_round[2] = 1'b1;
        end else begin
          in_valid[2] = 1'b0;
        end
      end
    end
    in_valid[2]  = 1'b0;
    out_ready[2] = 1'b0;
    check("b2b_outputs", 128'(nout), 128'd2);
    check("b2b_accepts", 128'(nacc), 128'd2);
    if (nacc >= 2) check("b2b_spacing", 128'(acc_cyc[1] - acc_cyc[0]), 128'd3);
    repeat (2) @(posedge clk);
    #1 check("b2b_idle", in_ready[2], 1'b1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic [127:0] st;
    logic         lr;
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid[i] = 1'b0; in_state[i] = '0; last_round[i] = 1'b0; out_ready[i] = 1'b0;
    end
    #12;
    for (int i = 0; i < 3; i++) check_reset(i);
    @(negedge clk);
    rst_n = 1'b1;

    do_op(0, T1In, 1'b0, T1Out, 0);
    do_op(0, T2In, 1'b1, T2In, 0);
    do_op(0, T1In, 1'b0, T1Out, 5);
    do_op(0, T6In, 1'b0, T6Out, 0);
    do_op(1, T1In, 1'b0, T1Out, 1);
    do_op(2, T6In, 1'b0, T6Out, 2);

    // Reset after two columns of a CALC on the 1-column instance.
    @(negedge clk);
    in_valid[0] = 1'b1;
    in_state[0] = rnd128();
    last_round[0] = 1'b0;
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    #1 check_reset(0);
    @(negedge clk);
    rst_n = 1'b1;
    do_op(0, C6In, 1'b0, C6In, 0);

    back_to_back();

    for (int i = 0; i < 3; i++) begin
      for (int n = 0; n < 8; n++) begin
        st = rnd128();
        lr = ($urandom_range(3) == 0);
        do_op(i, st, lr, lr ? st : mix_ref(st), int'($urandom_range(3)));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
